// File: rtl/chs_pkg.sv
// Shared definitions for the cooler/heater configuration encoder:
// word geometry, FSM state encoding and the request feasibility rule.
package chs_pkg;

    localparam int CHS_WIDTH = 8;
    localparam int CHS_PW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_DONE  = 2'd2
    } chs_state_e;

    // A word of CHS_WIDTH bits with bit0 pinned to mode can only hold
    // mode..(CHS_WIDTH-1+mode) ones.
    function automatic logic chs_feasible(input logic [CHS_PW-1:0] power, input logic mode);
        logic [CHS_PW-1:0] full;
        full = CHS_PW'(CHS_WIDTH);
        return (power <= full) &&
               !((power == '0) && mode) &&
               !((power == full) && !mode);
    endfunction

endpackage

// File: rtl/chs_conf_shreg.sv
// Serial-in configuration register: bits enter at the MSB and walk down,
// so the first bit shifted in lands at index 0 after WIDTH shifts.
module chs_conf_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= '0;
        else if (shift_en)
            q <= {sin, q[WIDTH-1:1]};
    end

endmodule

// File: rtl/chs_conf_encoder.sv
// Builds the chs_conf word one bit per cycle: bit0 = mode, then a run of
// (power - mode) ones from bit 1 upward, zeros above.
module chs_conf_encoder
    import chs_pkg::*;
#(
    parameter int WIDTH = CHS_WIDTH,
    parameter int PW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PW-1:0]    req_power,
    input  logic             req_mode,
    output logic [WIDTH-1:0] chs_conf,
    output logic             conf_valid,
    input  logic             conf_ack,
    output logic             conf_err
);

    chs_state_e        state;
    logic [PW-1:0]     bit_cnt;
    logic [PW-1:0]     ones_rem;
    logic              mode_q;
    logic [WIDTH-1:0]  shreg_q;

    logic              accept;
    logic              building;
    logic              cur_bit;
    logic              last_bit;
    logic [WIDTH-1:0]  built;

    assign accept   = req_valid && req_ready;
    assign building = (state == ST_BUILD);
    assign cur_bit  = (bit_cnt == '0) ? mode_q : (ones_rem != '0);
    assign last_bit = (bit_cnt == PW'(WIDTH - 1));
    // The final shift and the DONE load share an edge, so load the word
    // as it will be after that shift.
    assign built    = {cur_bit, shreg_q[WIDTH-1:1]};

    chs_conf_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .shift_en (building),
        .sin      (cur_bit),
        .q        (shreg_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            conf_valid <= 1'b0;
            conf_err   <= 1'b0;
            chs_conf   <= '0;
            bit_cnt    <= '0;
            ones_rem   <= '0;
            mode_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        mode_q    <= req_mode;
                        bit_cnt   <= '0;
                        if (chs_feasible(req_power, req_mode)) begin
                            ones_rem <= req_power - {{(PW-1){1'b0}}, req_mode};
                            state    <= ST_BUILD;
                        end else begin
                            ones_rem   <= '0;
                            chs_conf   <= '0;
                            conf_err   <= 1'b1;
                            conf_valid <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_BUILD: begin
                    bit_cnt <= bit_cnt + PW'(1);
                    if (bit_cnt != '0 && ones_rem != '0)
                        ones_rem <= ones_rem - PW'(1);
                    if (last_bit) begin
                        chs_conf   <= built;
                        conf_err   <= 1'b0;
                        conf_valid <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (conf_ack) begin
                        conf_valid <= 1'b0;
                        conf_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    conf_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
